// File: rtl/mux_rr_nch.sv
// N-channel, W-bit valid/ready multiplexer with a registered output stage.
// Channel chosen by round-robin or fixed select; define MUX_PARITY_EN to add out_parity.
module mux_rr_nch #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
`ifdef MUX_PARITY_EN
  output logic                      out_parity,
`endif
  input  logic                      out_ready
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_chan_q, out_chan_d;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [CHANNELS-1:0] grant_c;
  logic [SEL_W-1:0]    gnt_idx_c;
  logic [SEL_W-1:0]    gnt_nxt_c;
  logic [WIDTH-1:0]    gnt_data_c;
  logic                found_c;
  logic                load_en_c;
  logic                xfer_c;

  // Grant: fixed select, or first valid channel at or after rr_ptr (mod CHANNELS)
  always_comb begin
    grant_c    = '0;
    gnt_idx_c  = '0;
    gnt_nxt_c  = '0;
    gnt_data_c = '0;
    found_c    = 1'b0;
    if (mode) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_c[i] = 1'b1;
          gnt_idx_c  = SEL_W'(i);
          gnt_data_c = in_data[i*WIDTH +: WIDTH];
          found_c    = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (!found_c && in_valid[i] && (i == ((32'(rr_ptr_q) + k) % CHANNELS))) begin
            grant_c[i] = 1'b1;
            gnt_idx_c  = SEL_W'(i);
            gnt_nxt_c  = SEL_W'((i + 1) % CHANNELS);
            gnt_data_c = in_data[i*WIDTH +: WIDTH];
            found_c    = 1'b1;
          end
        end
      end
    end
  end

  assign load_en_c = (state_q == ST_EMPTY) | out_ready;
  assign xfer_c    = found_c & load_en_c & rst_n;
  // Nothing is accepted while reset is asserted
  assign in_ready  = grant_c & {CHANNELS{load_en_c & rst_n}};

  // Output stage next state: load on transfer, drain to EMPTY when nothing granted
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    rr_ptr_d   = rr_ptr_q;
    if (xfer_c) begin
      state_d    = ST_FULL;
      out_data_d = gnt_data_c;
      out_chan_d = gnt_idx_c;
      if (!mode) begin
        rr_ptr_d = gnt_nxt_c;
      end
    end else if (state_q == ST_FULL && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_chan_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = (state_q == ST_FULL);

`ifdef MUX_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (xfer_c) begin
      parity_d = ^gnt_data_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_rr_nch.sv
// Directed self-checking bench for mux_rr_nch (4 channels x 8 bits).
module tb_mux_rr_nch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;
`ifdef MUX_PARITY_EN
  logic        out_parity;
`endif

  int total  = 0;
  int passed = 0;

  mux_rr_nch #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
`ifdef MUX_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Assert reset for one cycle with the given inputs, release on a falling edge
  task automatic do_reset(input logic [3:0] v);
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    in_valid  = v;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    @(negedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL reset_data got %h exp 00", out_data); else passed++;
    total++; if (in_ready !== 4'h0) $display("FAIL reset_in_ready got %b exp 0000", in_ready); else passed++;
`ifdef MUX_PARITY_EN
    total++; if (out_parity !== 1'b0) $display("FAIL reset_parity got %b exp 0", out_parity); else passed++;
`endif
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) $display("FAIL first_valid got %b exp 1", out_valid); else passed++;
    total++; if (out_data !== 8'h11) $display("FAIL first_data got %h exp 11", out_data); else passed++;
    total++; if (out_chan !== 2'd0) $display("FAIL first_chan got %0d exp 0", out_chan); else passed++;
  endtask

  task automatic test_rr_all_valid;
    logic [7:0] exp_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic [1:0] exp_c [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset(4'hF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (out_data !== exp_d[k]) $display("FAIL rr_data[%0d] got %h exp %h", k, out_data, exp_d[k]); else passed++;
      total++; if (out_chan !== exp_c[k]) $display("FAIL rr_chan[%0d] got %0d exp %0d", k, out_chan, exp_c[k]); else passed++;
    end
  endtask

  task automatic test_backpressure;
    do_reset(4'hF);
    @(negedge clk);
    @(negedge clk);
    total++; if (out_data !== 8'h22) $display("FAIL bp_pre_data got %h exp 22", out_data); else passed++;
    out_ready = 1'b0;
    #1;
    total++; if (in_ready !== 4'h0) $display("FAIL bp_in_ready0 got %b exp 0000", in_ready); else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (out_data !== 8'h22 || out_valid !== 1'b1)
        $display("FAIL bp_hold[%0d] got %h/%b exp 22/1", k, out_data, out_valid); else passed++;
      total++; if (in_ready !== 4'h0) $display("FAIL bp_in_ready[%0d] got %b exp 0000", k, in_ready); else passed++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_data !== 8'h33 || out_chan !== 2'd2)
      $display("FAIL bp_next got %h/%0d exp 33/2", out_data, out_chan); else passed++;
  endtask

  task automatic test_fixed;
    do_reset(4'hF);
    @(negedge clk);
    mode     = 1'b1;
    sel      = 2'd2;
    in_valid = 4'b1011;
    #1;
    total++; if (in_ready !== 4'h0) $display("FAIL fix_in_ready got %b exp 0000", in_ready); else passed++;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL fix_drain_valid got %b exp 0", out_valid); else passed++;
    total++; if (out_data !== 8'h11) $display("FAIL fix_drain_data got %h exp 11", out_data); else passed++;
    in_valid = 4'hF;
    #1;
    total++; if (in_ready !== 4'b0100) $display("FAIL fix_in_ready2 got %b exp 0100", in_ready); else passed++;
    @(negedge clk);
    total++; if (out_data !== 8'h33 || out_chan !== 2'd2 || out_valid !== 1'b1)
      $display("FAIL fix_load got %h/%0d/%b exp 33/2/1", out_data, out_chan, out_valid); else passed++;
    // rr_ptr must still point at channel 1 after the fixed-mode beat
    mode = 1'b0;
    @(negedge clk);
    total++; if (out_data !== 8'h22 || out_chan !== 2'd1)
      $display("FAIL fix_rr_ptr_kept got %h/%0d exp 22/1", out_data, out_chan); else passed++;
  endtask

  task automatic test_sparse_wrap;
    do_reset(4'b0100);
    @(negedge clk);
    total++; if (out_chan !== 2'd2) $display("FAIL sp_setup got %0d exp 2", out_chan); else passed++;
    in_valid = 4'b0010;
    @(negedge clk);
    total++; if (out_data !== 8'h22 || out_chan !== 2'd1)
      $display("FAIL sp_wrap got %h/%0d exp 22/1", out_data, out_chan); else passed++;
    in_valid = 4'b1001;
    @(negedge clk);
    total++; if (out_data !== 8'h44 || out_chan !== 2'd3)
      $display("FAIL sp_ch3_first got %h/%0d exp 44/3", out_data, out_chan); else passed++;
    @(negedge clk);
    total++; if (out_data !== 8'h11 || out_chan !== 2'd0)
      $display("FAIL sp_ch0_next got %h/%0d exp 11/0", out_data, out_chan); else passed++;
  endtask

  task automatic test_async_reset;
    do_reset(4'hF);
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL ar_full got %b exp 1", out_valid); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL ar_valid got %b exp 0", out_valid); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL ar_data got %h exp 00", out_data); else passed++;
`ifdef MUX_PARITY_EN
    total++; if (out_parity !== 1'b0) $display("FAIL ar_parity got %b exp 0", out_parity); else passed++;
`endif
    @(negedge clk);
    in_valid  = 4'b0001;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h07};
    out_ready = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    total++; if (out_data !== 8'h07 || out_valid !== 1'b1)
      $display("FAIL par_load got %h/%b exp 07/1", out_data, out_valid); else passed++;
`ifdef MUX_PARITY_EN
    total++; if (out_parity !== 1'b1) $display("FAIL par_odd got %b exp 1", out_parity); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_rr_all_valid();
    test_backpressure();
    test_fixed();
    test_sparse_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
